// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchronizer, mid-bit sampling FSM,
// one-cycle rcv/ferr strobes and a break state that swallows held-low lines.
module uart_rx #(
    parameter int BAUDRATE = 1250
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx,
    output logic [7:0] data,
    output logic       rcv,
    output logic       ferr,
    output logic       busy
);

    localparam logic [15:0] BIT_LAST  = 16'(BAUDRATE - 1);
    localparam logic [15:0] HALF_LAST = 16'(BAUDRATE / 2 - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BRK   = 3'd4
    } state_t;

    state_t      state;
    logic        rx_p0;
    logic        rxs;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift;

    // Input synchronizer stage: rx -> rx_p0 -> rxs
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_p0 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            rx_p0 <= rx;
            rxs   <= rx_p0;
        end
    end

    // Shift register carries only data, so it needs no reset.
    always_ff @(posedge clk) begin
        if (state == DATA && baud_cnt == BIT_LAST) begin
            shift <= {rxs, shift[7:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= IDLE;
            data     <= 8'h00;
            rcv      <= 1'b0;
            ferr     <= 1'b0;
            busy     <= 1'b0;
            baud_cnt <= 16'd0;
            bit_cnt  <= 3'd0;
        end else begin
            rcv      <= 1'b0;
            ferr     <= 1'b0;
            baud_cnt <= baud_cnt + 16'd1;
            case (state)
                IDLE: begin
                    busy     <= 1'b0;
                    baud_cnt <= 16'd0;
                    if (!rxs) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (baud_cnt == HALF_LAST) begin
                        baud_cnt <= 16'd0;
                        bit_cnt  <= 3'd0;
                        if (rxs) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (baud_cnt == BIT_LAST) begin
                        baud_cnt <= 16'd0;
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (baud_cnt == BIT_LAST) begin
                        baud_cnt <= 16'd0;
                        if (rxs) begin
                            data  <= shift;
                            rcv   <= 1'b1;
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            ferr  <= 1'b1;
                            state <= BRK;
                        end
                    end
                end
                BRK: begin
                    // A held-low line must not restart frames until it idles high.
                    baud_cnt <= 16'd0;
                    if (rxs) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    baud_cnt <= 16'd0;
                end
            endcase
        end
    end

endmodule
